// File: rtl/imem_loader_if.sv
// Loader-side bundle: start request, byte stream handshake, instruction-memory
// write port and load status. master = stream/boot controller, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit imem writes, mem_we one cycle after a word's 4th byte.
// Backpressure: rx_ready drops during WRITE/IDLE/DONE/ERR; rx_valid gaps stall with all state held, no timeout.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     buf_q, buf_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  logic            rx_ready;
  logic            hs;
  logic [15:0]     len_new;
  logic [ADDR_W:0] cnt_inc;

  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            busy;

  assign hs      = bus.rx_valid & rx_ready;
  assign len_new = {bus.rx_data, len_q[7:0]};
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = LEN0;
          len_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      LEN0: begin
        if (hs) begin
          len_d[7:0] = bus.rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (hs) begin
          len_d = len_new;
          if (len_new == 16'd0 || {1'b0, len_new} > 17'(DEPTH)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Shifting in from the top leaves the first byte of the word in [7:0].
        if (hs) begin
          buf_d = {bus.rx_data, buf_q[31:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_inc;
        if (16'(cnt_inc) == len_q) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      LEN0, LEN1, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = BASE_ADDR + (32'(cnt_q) << 2);
        mem_wdata = buf_q;
      end
      default: ;
    endcase
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == ERR);
  assign bus.word_cnt  = cnt_q;
endmodule
